mcse_resource_arbiter: RTL and testbench
========================================

# mcse_resource_arbiter

Parametrised N-client arbiter that shares the secure memory port, the bus translation unit port and the SHA engine port among MCSE control masters (secure boot, firmware authentication, lifecycle, future clients). It sits inside the control unit between the masters and the shared resources. It replaces the static two-way select with request/grant ownership and fixed-priority or round-robin arbitration. It adds drain of outstanding transactions on hand-over and a watchdog that revokes a stalled owner.

## Interface
- N_CLIENTS, 2: number of masters; must be ≥ 2.
- MEM_WIDTH, 256: secure memory data width.
- MEM_DEPTH, 16: secure memory depth; MAW = $clog2(MEM_DEPTH).
- AHB_ADDR_WIDTH, 32: bus address width.
- PAYLOAD_BITS, 128: bus payload width.
- ARB_MODE, 0: 0 = fixed priority, lowest index wins; 1 = round-robin.
- TIMEOUT_CYCLES, 1024: maximum grant length; 0 disables the watchdog.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cl_req  in  N  per-client ownership request, level.
- cl_release  in  N  per-client one-cycle release pulse.
- cl_grant  out  N  one-hot ownership, registered.
- cl_timeout  out  N  one-cycle pulse when the watchdog revokes a client.
- cl_mem_ctrl  in  N*2  per client {rd_en, wr_en}.
- cl_mem_addr / cl_mem_wrData  in  N*MAW / N*MEM_WIDTH  per-client memory address and write data.
- mem_rd_en, mem_wr_en  out  1 each  to secure memory.
- mem_addr, mem_wrData  out  MAW, MEM_WIDTH  to secure memory.
- mem_rdData, mem_rdData_valid  in  MEM_WIDTH, 1  from secure memory.
- cl_mem_rdData  out  MEM_WIDTH  broadcast read data.
- cl_mem_rdData_valid  out  N  valid, routed to the owner only.
- cl_bus_ctrl  in  N*2  per client {go, RW}.
- cl_bus_addr / cl_bus_write  in  N*AHB_ADDR_WIDTH / N*PAYLOAD_BITS  per-client bus address and write payload.
- bus_go, bus_RW, bus_addr, bus_write  out  1, 1, AHB_ADDR_WIDTH, PAYLOAD_BITS  to the bus translation unit.
- bus_done, bus_rdData  in  1, PAYLOAD_BITS  from the bus translation unit.
- cl_bus_done  out  N  done, routed to the owner only.
- cl_bus_rdData  out  PAYLOAD_BITS  broadcast bus read data.
- cl_sha_ctrl / cl_sha_block  in  N*3 / N*512  per client {init, next, sel} and message block.
- sha_init, sha_next, sha_sel, sha_block  out  1, 1, 1, 512  to SHA.

## Operation
- FSM states are IDLE, GRANT and DRAIN. A registered owner index is held from grant until the FSM returns to IDLE.
- IDLE: if any cl_req bit is set, the picker selects a winner. The winner is registered as owner, cl_grant[owner] rises, and the FSM moves to GRANT.
- GRANT: the owner's strobes and data pass to the shared outputs. Strobes from non-owners are ignored.
- GRANT exit: cl_release[owner], a cl_req[owner] deassert, or watchdog expiry moves the FSM to DRAIN and drops cl_grant.
- DRAIN: all outgoing strobes are forced to 0. Returns (cl_bus_done, cl_mem_rdData_valid) still route to the owner. The FSM moves to IDLE once bus_pend and mem_pend are both 0.
- bus_pend is set on a forwarded bus_go and cleared on bus_done. mem_pend is set on a forwarded mem_rd_en and cleared on mem_rdData_valid. If set and clear occur in the same cycle, the flag stays set.
- Watchdog: the counter clears on grant and increments each GRANT cycle. At TIMEOUT_CYCLES-1 the FSM enters DRAIN and pulses cl_timeout[owner].
- Round-robin: the pointer updates to the owner on each grant. The search starts at pointer+1 and wraps modulo N_CLIENTS.
- Outside GRANT, all shared output strobes and data are 0. Returns that arrive in IDLE are dropped.
- cl_release from a non-owner is ignored.

## Timing
- Reset values: all outputs 0, FSM in IDLE, owner 0, RR pointer N_CLIENTS-1 (the first RR pick is client 0), both pend flags and the watchdog counter 0.
- Grant latency: cl_req rises in cycle t; cl_grant is high in cycle t+1, and the owner's strobes pass from t+1.
- Strobe passthrough is combinational: the owner's strobe, gated by GRANT, appears on the shared output in the same cycle.
- Hand-over with nothing pending: release in cycle t, DRAIN in t+1, IDLE in t+2, next grant in t+3.
- Reset mid-transaction: state is cleared immediately and outstanding returns are discarded.

## Structure
- Package mcse_arb_pkg holds:
  - the arb_state_e enum (IDLE, GRANT, DRAIN);
  - ARB_FIXED = 0 and ARB_RR = 1;
  - the width function for the owner index.
- Sub-module mcse_arb_picker: combinational winner select from (req, pointer, mode). Outputs are a one-hot vector and an index.

## Test plan
- Fixed priority, reset, then cl_req = 2'b11 at cycle 2 -> cl_grant = 2'b01 at cycle 3; client 1 waits until client 0 releases, then cl_grant = 2'b10 three cycles after the release.
- RR with N_CLIENTS = 3, all three requesting continuously and each releasing after 4 cycles -> grant order 0, 1, 2, 0.
- Owner issues bus_go, then releases before bus_done; bus_done arrives 5 cycles later -> FSM stays in DRAIN, cl_bus_done goes to the old owner only, and the next grant comes after the done.
- TIMEOUT_CYCLES = 8 with the owner holding cl_req -> cl_timeout pulses 8 cycles after grant, grant drops, and the waiting client is granted.
- Non-owner asserts mem_wr_en with addr 3 -> mem_wr_en stays 0 and memory is untouched.
- Assert rst_n low while in DRAIN with mem_pend = 1 -> all outputs read 0 at once, and the FSM returns to IDLE after reset.

Source files
------------

// File: rtl/mcse_arb_pkg.sv
// Shared types and constants for the MCSE resource arbiter.
//   arb_state_e     : arbiter FSM states (IDLE, GRANT, DRAIN)
//   ARB_FIXED/ARB_RR: arbitration mode encodings
//   SHA_BLOCK_BITS  : SHA message block width
//   owner_width()   : bit width of an owner index for a given client count
package mcse_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

    localparam int ARB_FIXED      = 0;
    localparam int ARB_RR         = 1;
    localparam int SHA_BLOCK_BITS = 512;

    // Owner index width; at least one bit so single-bit indices stay legal.
    function automatic int owner_width(input int n_clients);
        return (n_clients > 1) ? $clog2(n_clients) : 1;
    endfunction

endpackage

// File: rtl/mcse_arb_picker.sv
// Combinational winner select for the MCSE resource arbiter.
//   req       in  N   request vector
//   ptr       in  IW  round-robin pointer (last owner)
//   rr_mode   in  1   0 = lowest index wins, 1 = search from ptr+1 with wrap
//   grant_oh  out N   one-hot winner (all zero when nobody requests)
//   grant_idx out IW  winner index
//   valid     out 1   some client requested
module mcse_arb_picker
    import mcse_arb_pkg::*;
#(
    parameter  int N_CLIENTS = 2,
    localparam int IW        = owner_width(N_CLIENTS)
) (
    input  logic [N_CLIENTS-1:0] req,
    input  logic [IW-1:0]        ptr,
    input  logic                 rr_mode,
    output logic [N_CLIENTS-1:0] grant_oh,
    output logic [IW-1:0]        grant_idx,
    output logic                 valid
);

    // Scan candidates in priority order; the first requester found wins.
    always_comb begin : pick_search
        int   cand;
        logic hit;
        cand      = 0;
        hit       = 1'b0;
        valid     = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            // ptr never exceeds N-1, so one wrap subtraction is enough.
            cand      = rr_mode ? (int'(ptr) + 1 + i) : i;
            cand      = (cand >= N_CLIENTS) ? (cand - N_CLIENTS) : cand;
            hit       = !valid && req[cand[IW-1:0]];
            grant_idx = hit ? cand[IW-1:0] : grant_idx;
            valid     = valid | hit;
        end
    end

    // Expand the winning index into a one-hot vector.
    always_comb begin
        grant_oh = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            grant_oh[i] = valid && (grant_idx == IW'(i));
        end
    end

endmodule

// File: rtl/mcse_resource_arbiter.sv
// N-client ownership arbiter for the secure memory, bus translation unit and
// SHA engine ports of the MCSE control unit.
//   clk, rst_n                  clock, asynchronous active-low reset
//   cl_req / cl_release         per-client request level / release pulse
//   cl_grant / cl_timeout       registered one-hot ownership / watchdog revoke pulse
//   cl_mem_* , mem_*            per-client memory strobes/data and shared memory port
//   cl_bus_* , bus_*            per-client bus strobes/data and shared bus port
//   cl_sha_* , sha_*            per-client SHA controls/block and shared SHA port
// Only the owner's strobes reach the shared ports, and only in GRANT. Returns
// (read valid, bus done) are routed to the owner in GRANT and DRAIN.
module mcse_resource_arbiter
    import mcse_arb_pkg::*;
#(
    parameter  int N_CLIENTS      = 2,
    parameter  int MEM_WIDTH      = 256,
    parameter  int MEM_DEPTH      = 16,
    parameter  int AHB_ADDR_WIDTH = 32,
    parameter  int PAYLOAD_BITS   = 128,
    parameter  int ARB_MODE       = 0,
    parameter  int TIMEOUT_CYCLES = 1024,
    localparam int MAW            = $clog2(MEM_DEPTH)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [N_CLIENTS-1:0]                 cl_req,
    input  logic [N_CLIENTS-1:0]                 cl_release,
    output logic [N_CLIENTS-1:0]                 cl_grant,
    output logic [N_CLIENTS-1:0]                 cl_timeout,
    input  logic [N_CLIENTS*2-1:0]               cl_mem_ctrl,
    input  logic [N_CLIENTS*MAW-1:0]             cl_mem_addr,
    input  logic [N_CLIENTS*MEM_WIDTH-1:0]       cl_mem_wrData,
    output logic                                 mem_rd_en,
    output logic                                 mem_wr_en,
    output logic [MAW-1:0]                       mem_addr,
    output logic [MEM_WIDTH-1:0]                 mem_wrData,
    input  logic [MEM_WIDTH-1:0]                 mem_rdData,
    input  logic                                 mem_rdData_valid,
    output logic [MEM_WIDTH-1:0]                 cl_mem_rdData,
    output logic [N_CLIENTS-1:0]                 cl_mem_rdData_valid,
    input  logic [N_CLIENTS*2-1:0]               cl_bus_ctrl,
    input  logic [N_CLIENTS*AHB_ADDR_WIDTH-1:0]  cl_bus_addr,
    input  logic [N_CLIENTS*PAYLOAD_BITS-1:0]    cl_bus_write,
    output logic                                 bus_go,
    output logic                                 bus_RW,
    output logic [AHB_ADDR_WIDTH-1:0]            bus_addr,
    output logic [PAYLOAD_BITS-1:0]              bus_write,
    input  logic                                 bus_done,
    input  logic [PAYLOAD_BITS-1:0]              bus_rdData,
    output logic [N_CLIENTS-1:0]                 cl_bus_done,
    output logic [PAYLOAD_BITS-1:0]              cl_bus_rdData,
    input  logic [N_CLIENTS*3-1:0]               cl_sha_ctrl,
    input  logic [N_CLIENTS*SHA_BLOCK_BITS-1:0]  cl_sha_block,
    output logic                                 sha_init,
    output logic                                 sha_next,
    output logic                                 sha_sel,
    output logic [SHA_BLOCK_BITS-1:0]            sha_block
);

    localparam int             IW      = owner_width(N_CLIENTS);
    localparam int             WDW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit             WD_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam logic           RR_MODE = (ARB_MODE == ARB_RR);

    arb_state_e             state_r, state_nxt_s;
    logic [IW-1:0]          owner_r, owner_nxt_s;
    logic [IW-1:0]          ptr_r, ptr_nxt_s;
    logic [WDW-1:0]         wd_cnt_r, wd_cnt_nxt_s;
    logic [N_CLIENTS-1:0]   grant_nxt_s, timeout_nxt_s;
    logic                   bus_pend_r, mem_pend_r;

    logic [N_CLIENTS-1:0]   pick_oh_s;
    logic [IW-1:0]          pick_idx_s;
    logic                   pick_valid_s;

    logic [N_CLIENTS-1:0]   owner_oh_s;
    logic [1:0]             own_mem_ctrl_s;
    logic [MAW-1:0]         own_mem_addr_s;
    logic [MEM_WIDTH-1:0]   own_mem_wdata_s;
    logic [1:0]             own_bus_ctrl_s;
    logic [AHB_ADDR_WIDTH-1:0] own_bus_addr_s;
    logic [PAYLOAD_BITS-1:0] own_bus_write_s;
    logic [2:0]             own_sha_ctrl_s;
    logic [SHA_BLOCK_BITS-1:0] own_sha_block_s;

    logic                   in_grant_s;
    logic                   in_service_s;
    logic                   wd_expire_s;
    logic                   owner_exit_s;

    mcse_arb_picker #(
        .N_CLIENTS (N_CLIENTS)
    ) u_picker (
        .req       (cl_req),
        .ptr       (ptr_r),
        .rr_mode   (RR_MODE),
        .grant_oh  (pick_oh_s),
        .grant_idx (pick_idx_s),
        .valid     (pick_valid_s)
    );

    // Select the owner's request fields with an AND-OR mux over the owner one-hot.
    always_comb begin
        owner_oh_s      = '0;
        own_mem_ctrl_s  = '0;
        own_mem_addr_s  = '0;
        own_mem_wdata_s = '0;
        own_bus_ctrl_s  = '0;
        own_bus_addr_s  = '0;
        own_bus_write_s = '0;
        own_sha_ctrl_s  = '0;
        own_sha_block_s = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            owner_oh_s[i]   = (owner_r == IW'(i));
            own_mem_ctrl_s  = own_mem_ctrl_s  | (cl_mem_ctrl[i*2 +: 2] & {2{owner_oh_s[i]}});
            own_mem_addr_s  = own_mem_addr_s  | (cl_mem_addr[i*MAW +: MAW] & {MAW{owner_oh_s[i]}});
            own_mem_wdata_s = own_mem_wdata_s | (cl_mem_wrData[i*MEM_WIDTH +: MEM_WIDTH] & {MEM_WIDTH{owner_oh_s[i]}});
            own_bus_ctrl_s  = own_bus_ctrl_s  | (cl_bus_ctrl[i*2 +: 2] & {2{owner_oh_s[i]}});
            own_bus_addr_s  = own_bus_addr_s  | (cl_bus_addr[i*AHB_ADDR_WIDTH +: AHB_ADDR_WIDTH] & {AHB_ADDR_WIDTH{owner_oh_s[i]}});
            own_bus_write_s = own_bus_write_s | (cl_bus_write[i*PAYLOAD_BITS +: PAYLOAD_BITS] & {PAYLOAD_BITS{owner_oh_s[i]}});
            own_sha_ctrl_s  = own_sha_ctrl_s  | (cl_sha_ctrl[i*3 +: 3] & {3{owner_oh_s[i]}});
            own_sha_block_s = own_sha_block_s | (cl_sha_block[i*SHA_BLOCK_BITS +: SHA_BLOCK_BITS] & {SHA_BLOCK_BITS{owner_oh_s[i]}});
        end
    end

    assign in_grant_s   = (state_r == GRANT);
    assign in_service_s = (state_r != IDLE);
    assign wd_expire_s  = WD_EN && (wd_cnt_r == WD_LAST);
    assign owner_exit_s = (|(cl_release & owner_oh_s)) || !(|(cl_req & owner_oh_s)) || wd_expire_s;

    // Shared request ports: owner passthrough in GRANT, forced to zero otherwise.
    assign mem_rd_en  = own_mem_ctrl_s[1] & in_grant_s;
    assign mem_wr_en  = own_mem_ctrl_s[0] & in_grant_s;
    assign mem_addr   = own_mem_addr_s  & {MAW{in_grant_s}};
    assign mem_wrData = own_mem_wdata_s & {MEM_WIDTH{in_grant_s}};
    assign bus_go     = own_bus_ctrl_s[1] & in_grant_s;
    assign bus_RW     = own_bus_ctrl_s[0] & in_grant_s;
    assign bus_addr   = own_bus_addr_s  & {AHB_ADDR_WIDTH{in_grant_s}};
    assign bus_write  = own_bus_write_s & {PAYLOAD_BITS{in_grant_s}};
    assign sha_init   = own_sha_ctrl_s[2] & in_grant_s;
    assign sha_next   = own_sha_ctrl_s[1] & in_grant_s;
    assign sha_sel    = own_sha_ctrl_s[0] & in_grant_s;
    assign sha_block  = own_sha_block_s & {SHA_BLOCK_BITS{in_grant_s}};

    // Returns keep flowing to the owner while draining; dropped in IDLE.
    assign cl_mem_rdData       = mem_rdData & {MEM_WIDTH{in_service_s}};
    assign cl_mem_rdData_valid = owner_oh_s & {N_CLIENTS{mem_rdData_valid & in_service_s}};
    assign cl_bus_done         = owner_oh_s & {N_CLIENTS{bus_done & in_service_s}};
    assign cl_bus_rdData       = bus_rdData & {PAYLOAD_BITS{in_service_s}};

    // Next-state, grant, watchdog and pointer decisions.
    always_comb begin
        state_nxt_s   = state_r;
        owner_nxt_s   = owner_r;
        ptr_nxt_s     = ptr_r;
        wd_cnt_nxt_s  = wd_cnt_r;
        grant_nxt_s   = cl_grant;
        timeout_nxt_s = '0;
        case (state_r)
            IDLE: begin
                if (pick_valid_s) begin
                    state_nxt_s  = GRANT;
                    owner_nxt_s  = pick_idx_s;
                    ptr_nxt_s    = pick_idx_s;
                    wd_cnt_nxt_s = '0;
                    grant_nxt_s  = pick_oh_s;
                end else begin
                    grant_nxt_s  = '0;
                end
            end
            GRANT: begin
                if (owner_exit_s) begin
                    state_nxt_s   = DRAIN;
                    grant_nxt_s   = '0;
                    timeout_nxt_s = owner_oh_s & {N_CLIENTS{wd_expire_s}};
                end else begin
                    wd_cnt_nxt_s  = wd_cnt_r + WDW'(1);
                end
            end
            DRAIN: begin
                grant_nxt_s = '0;
                if (!bus_pend_r && !mem_pend_r) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                grant_nxt_s = '0;
            end
        endcase
    end

    // FSM, owner, pointer, watchdog and registered grant/timeout outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            owner_r    <= '0;
            ptr_r      <= IW'(N_CLIENTS - 1);
            wd_cnt_r   <= '0;
            cl_grant   <= '0;
            cl_timeout <= '0;
        end else begin
            state_r    <= state_nxt_s;
            owner_r    <= owner_nxt_s;
            ptr_r      <= ptr_nxt_s;
            wd_cnt_r   <= wd_cnt_nxt_s;
            cl_grant   <= grant_nxt_s;
            cl_timeout <= timeout_nxt_s;
        end
    end

    // Outstanding-transaction flags; a set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_pend_r <= 1'b0;
            mem_pend_r <= 1'b0;
        end else begin
            if (bus_go) begin
                bus_pend_r <= 1'b1;
            end else if (bus_done) begin
                bus_pend_r <= 1'b0;
            end else begin
                bus_pend_r <= bus_pend_r;
            end
            if (mem_rd_en) begin
                mem_pend_r <= 1'b1;
            end else if (mem_rdData_valid) begin
                mem_pend_r <= 1'b0;
            end else begin
                mem_pend_r <= mem_pend_r;
            end
        end
    end

endmodule

// File: tb/tb_mcse_resource_arbiter.sv
// Directed bench: a fixed-priority 2-client instance (watchdog 8 cycles) and a
// round-robin 3-client instance (watchdog disabled), hand-computed expectations.
module tb_mcse_resource_arbiter;

    localparam int MW = 16;
    localparam int MA = 4;
    localparam int AW = 16;
    localparam int PB = 16;

    logic clk;
    int   n_cmp;
    int   n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- fixed-priority instance ----------------
    logic           f_rst_n;
    logic [1:0]     f_req, f_rel, f_grant, f_to;
    logic [3:0]     f_mem_ctrl;
    logic [7:0]     f_mem_addr;
    logic [31:0]    f_mem_wd;
    logic           f_mem_rd_en, f_mem_wr_en;
    logic [MA-1:0]  f_mem_addr_o;
    logic [MW-1:0]  f_mem_wd_o, f_mem_rd, f_cl_mem_rd;
    logic           f_mem_rv;
    logic [1:0]     f_cl_mem_rv;
    logic [3:0]     f_bus_ctrl;
    logic [31:0]    f_bus_addr, f_bus_wr;
    logic           f_bus_go, f_bus_rw, f_bus_done;
    logic [AW-1:0]  f_bus_addr_o;
    logic [PB-1:0]  f_bus_wr_o, f_bus_rd, f_cl_bus_rd;
    logic [1:0]     f_cl_bus_done;
    logic [5:0]     f_sha_ctrl;
    logic [1023:0]  f_sha_blk;
    logic           f_sha_init, f_sha_next, f_sha_sel;
    logic [511:0]   f_sha_blk_o;
    logic [511:0]   blk0;

    mcse_resource_arbiter #(
        .N_CLIENTS(2), .MEM_WIDTH(MW), .MEM_DEPTH(16), .AHB_ADDR_WIDTH(AW),
        .PAYLOAD_BITS(PB), .ARB_MODE(0), .TIMEOUT_CYCLES(8)
    ) dut_fx (
        .clk(clk), .rst_n(f_rst_n), .cl_req(f_req), .cl_release(f_rel),
        .cl_grant(f_grant), .cl_timeout(f_to),
        .cl_mem_ctrl(f_mem_ctrl), .cl_mem_addr(f_mem_addr), .cl_mem_wrData(f_mem_wd),
        .mem_rd_en(f_mem_rd_en), .mem_wr_en(f_mem_wr_en), .mem_addr(f_mem_addr_o),
        .mem_wrData(f_mem_wd_o), .mem_rdData(f_mem_rd), .mem_rdData_valid(f_mem_rv),
        .cl_mem_rdData(f_cl_mem_rd), .cl_mem_rdData_valid(f_cl_mem_rv),
        .cl_bus_ctrl(f_bus_ctrl), .cl_bus_addr(f_bus_addr), .cl_bus_write(f_bus_wr),
        .bus_go(f_bus_go), .bus_RW(f_bus_rw), .bus_addr(f_bus_addr_o), .bus_write(f_bus_wr_o),
        .bus_done(f_bus_done), .bus_rdData(f_bus_rd), .cl_bus_done(f_cl_bus_done),
        .cl_bus_rdData(f_cl_bus_rd), .cl_sha_ctrl(f_sha_ctrl), .cl_sha_block(f_sha_blk),
        .sha_init(f_sha_init), .sha_next(f_sha_next), .sha_sel(f_sha_sel), .sha_block(f_sha_blk_o)
    );

    // ---------------- round-robin instance ----------------
    logic           r_rst_n;
    logic [2:0]     r_req, r_rel, r_grant, r_to;
    logic [5:0]     r_mem_ctrl;
    logic [11:0]    r_mem_addr;
    logic [47:0]    r_mem_wd;
    logic           r_mem_rd_en, r_mem_wr_en;
    logic [MA-1:0]  r_mem_addr_o;
    logic [MW-1:0]  r_mem_wd_o, r_mem_rd, r_cl_mem_rd;
    logic           r_mem_rv;
    logic [2:0]     r_cl_mem_rv;
    logic [5:0]     r_bus_ctrl;
    logic [47:0]    r_bus_addr, r_bus_wr;
    logic           r_bus_go, r_bus_rw, r_bus_done;
    logic [AW-1:0]  r_bus_addr_o;
    logic [PB-1:0]  r_bus_wr_o, r_bus_rd, r_cl_bus_rd;
    logic [2:0]     r_cl_bus_done;
    logic [8:0]     r_sha_ctrl;
    logic [1535:0]  r_sha_blk;
    logic           r_sha_init, r_sha_next, r_sha_sel;
    logic [511:0]   r_sha_blk_o;

    mcse_resource_arbiter #(
        .N_CLIENTS(3), .MEM_WIDTH(MW), .MEM_DEPTH(16), .AHB_ADDR_WIDTH(AW),
        .PAYLOAD_BITS(PB), .ARB_MODE(1), .TIMEOUT_CYCLES(0)
    ) dut_rr (
        .clk(clk), .rst_n(r_rst_n), .cl_req(r_req), .cl_release(r_rel),
        .cl_grant(r_grant), .cl_timeout(r_to),
        .cl_mem_ctrl(r_mem_ctrl), .cl_mem_addr(r_mem_addr), .cl_mem_wrData(r_mem_wd),
        .mem_rd_en(r_mem_rd_en), .mem_wr_en(r_mem_wr_en), .mem_addr(r_mem_addr_o),
        .mem_wrData(r_mem_wd_o), .mem_rdData(r_mem_rd), .mem_rdData_valid(r_mem_rv),
        .cl_mem_rdData(r_cl_mem_rd), .cl_mem_rdData_valid(r_cl_mem_rv),
        .cl_bus_ctrl(r_bus_ctrl), .cl_bus_addr(r_bus_addr), .cl_bus_write(r_bus_wr),
        .bus_go(r_bus_go), .bus_RW(r_bus_rw), .bus_addr(r_bus_addr_o), .bus_write(r_bus_wr_o),
        .bus_done(r_bus_done), .bus_rdData(r_bus_rd), .cl_bus_done(r_cl_bus_done),
        .cl_bus_rdData(r_cl_bus_rd), .cl_sha_ctrl(r_sha_ctrl), .cl_sha_block(r_sha_blk),
        .sha_init(r_sha_init), .sha_next(r_sha_next), .sha_sel(r_sha_sel), .sha_block(r_sha_blk_o)
    );

    // Count one comparison and report it when observed differs from expected.
    task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge (input drive point).
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Move to the falling edge (sample point).
    task automatic smp();
        @(negedge clk);
    endtask

    // Stimulus and checks: fixed-priority scenarios first, then round-robin.
    initial begin : stim
        logic [2:0] rr_exp;
        logic [2:0] to_seen;
        n_cmp = 0;
        n_err = 0;
        blk0  = {16{32'hA1B2C3D4}};
        f_rst_n = 1'b0; f_req = '0; f_rel = '0; f_mem_ctrl = '0; f_mem_addr = '0;
        f_mem_wd = '0; f_mem_rd = '0; f_mem_rv = 1'b0; f_bus_ctrl = '0; f_bus_addr = '0;
        f_bus_wr = '0; f_bus_done = 1'b0; f_bus_rd = '0; f_sha_ctrl = '0; f_sha_blk = '0;
        r_rst_n = 1'b0; r_req = '0; r_rel = '0; r_mem_ctrl = '0; r_mem_addr = '0;
        r_mem_wd = '0; r_mem_rd = '0; r_mem_rv = 1'b0; r_bus_ctrl = '0; r_bus_addr = '0;
        r_bus_wr = '0; r_bus_done = 1'b0; r_bus_rd = '0; r_sha_ctrl = '0; r_sha_blk = '0;

        step(); smp();
        check_eq("rst_grant", f_grant, 2'b00);
        check_eq("rst_timeout", f_to, 2'b00);
        check_eq("rst_strobes", {f_mem_rd_en, f_mem_wr_en, f_bus_go, f_sha_init}, 4'b0000);

        // cycle 0..1: idle after reset
        step(); f_rst_n = 1'b1; smp();
        step(); smp();
        // cycle 2: both request
        step(); f_req = 2'b11; smp();
        check_eq("grant_c2", f_grant, 2'b00);
        // cycle 3: lowest index owns
        step(); smp();
        check_eq("grant_c3", f_grant, 2'b01);
        // cycle 4: owner strobes pass through
        step();
        f_mem_ctrl = {2'b00, 2'b01}; f_mem_addr = {4'd3, 4'd5}; f_mem_wd = {16'hBBBB, 16'hA5A5};
        f_sha_ctrl = {3'b010, 3'b101}; f_sha_blk = {512'h2, blk0};
        smp();
        check_eq("own_wr_en", f_mem_wr_en, 1'b1);
        check_eq("own_addr", f_mem_addr_o, 4'd5);
        check_eq("own_wdata", f_mem_wd_o, 16'hA5A5);
        check_eq("own_sha_ctrl", {f_sha_init, f_sha_next, f_sha_sel}, 3'b101);
        check_eq("own_sha_blk", f_sha_blk_o, blk0);
        // cycle 5: non-owner write to addr 3 is ignored
        step();
        f_mem_ctrl = {2'b01, 2'b00}; f_mem_addr = {4'd3, 4'd0}; f_mem_wd = {16'hBBBB, 16'h0000};
        f_sha_ctrl = '0; f_sha_blk = '0;
        smp();
        check_eq("nonowner_wr_en", f_mem_wr_en, 1'b0);
        check_eq("nonowner_addr", f_mem_addr_o, 4'd0);
        check_eq("nonowner_wdata", f_mem_wd_o, 16'h0000);
        // cycle 6: owner releases, drops its request
        step(); f_mem_ctrl = '0; f_mem_addr = '0; f_mem_wd = '0; f_rel = 2'b01; f_req = 2'b10; smp();
        check_eq("rel_cycle_grant", f_grant, 2'b01);
        step(); f_rel = 2'b00; smp();
        check_eq("drain_grant", f_grant, 2'b00);
        step(); smp();
        check_eq("idle_grant", f_grant, 2'b00);
        step(); smp();
        check_eq("handover_grant", f_grant, 2'b10);

        // cycle 10: owner 1 issues bus_go
        step();
        f_bus_ctrl = {2'b11, 2'b10}; f_bus_addr = {16'h1234, 16'h9999}; f_bus_wr = {16'hCAFE, 16'h0000};
        smp();
        check_eq("bus_fwd", {f_bus_go, f_bus_rw, f_bus_addr_o, f_bus_wr_o}, {2'b11, 16'h1234, 16'hCAFE});
        // cycle 11: release before bus_done
        step(); f_bus_ctrl = '0; f_bus_addr = '0; f_bus_wr = '0; f_rel = 2'b10; f_req = 2'b00; smp();
        check_eq("bus_rel_grant", f_grant, 2'b10);
        // cycle 12: draining, stray go blocked
        step(); f_rel = 2'b00; f_req = 2'b10; f_bus_ctrl = {2'b10, 2'b00}; smp();
        check_eq("drain_go_gated", f_bus_go, 1'b0);
        check_eq("drain_c12", f_grant, 2'b00);
        for (int i = 0; i < 3; i++) begin
            step(); f_bus_ctrl = '0; smp();
            check_eq("drain_wait", f_grant, 2'b00);
        end
        // cycle 16: bus_done arrives, routed to old owner only
        step(); f_bus_done = 1'b1; f_bus_rd = 16'h5A5A; smp();
        check_eq("done_route", f_cl_bus_done, 2'b10);
        check_eq("done_data", f_cl_bus_rd, 16'h5A5A);
        step(); f_bus_done = 1'b0; f_bus_rd = '0; smp();
        check_eq("drain_after_done", f_grant, 2'b00);
        step(); smp();
        check_eq("idle_after_done", f_grant, 2'b00);
        step(); smp();
        check_eq("regrant_after_done", f_grant, 2'b10);

        // cycle 20: client 0 waits while client 1 stalls
        step(); f_req = 2'b11; smp();
        check_eq("wd_no_pulse", f_to, 2'b00);
        for (int i = 0; i < 5; i++) begin
            step(); smp();
        end
        step(); smp();
        check_eq("wd_last_grant", {f_grant, f_to}, {2'b10, 2'b00});
        step(); smp();
        check_eq("wd_pulse", {f_grant, f_to}, {2'b00, 2'b10});
        step(); smp();
        check_eq("wd_pulse_end", f_to, 2'b00);
        step(); smp();
        check_eq("waiter_granted", f_grant, 2'b01);

        // cycle 30: owner 0 reads, valid in same cycle keeps mem_pend set
        step(); f_mem_ctrl = {2'b00, 2'b10}; f_mem_rv = 1'b1; f_mem_rd = 16'hD00D; smp();
        check_eq("rd_fwd", f_mem_rd_en, 1'b1);
        check_eq("rv_route", f_cl_mem_rv, 2'b01);
        check_eq("rd_data", f_cl_mem_rd, 16'hD00D);
        step(); f_mem_ctrl = '0; f_mem_rv = 1'b0; f_mem_rd = '0; f_rel = 2'b01; f_req = 2'b10; smp();
        check_eq("rd_rel_grant", f_grant, 2'b01);
        for (int i = 0; i < 3; i++) begin
            step(); f_rel = 2'b00; smp();
            check_eq("mem_pend_hold", f_grant, 2'b00);
        end
        // cycle 35: reset while draining with mem_pend set
        step(); f_rst_n = 1'b0; f_mem_rv = 1'b1; f_mem_rd = 16'hBEEF;
        f_mem_ctrl = {2'b01, 2'b10}; f_bus_done = 1'b1;
        smp();
        check_eq("rst_mid_grant", f_grant, 2'b00);
        check_eq("rst_mid_strobes", {f_mem_rd_en, f_mem_wr_en}, 2'b00);
        check_eq("rst_mid_returns", {f_cl_mem_rv, f_cl_bus_done}, 4'b0000);
        check_eq("rst_mid_rdata", f_cl_mem_rd, 16'h0000);
        step(); f_rst_n = 1'b1; f_mem_rv = 1'b0; f_mem_rd = '0; f_mem_ctrl = '0; f_bus_done = 1'b0; smp();
        check_eq("post_rst_idle", f_grant, 2'b00);
        step(); smp();
        check_eq("post_rst_grant", f_grant, 2'b10);

        // ---------------- round-robin ----------------
        step(); r_rst_n = 1'b1; smp();
        step(); r_req = 3'b111; smp();
        check_eq("rr_latency", r_grant, 3'b000);
        for (int k = 0; k < 4; k++) begin
            rr_exp = 3'b001 << (k % 3);
            step(); smp();
            check_eq("rr_order", r_grant, rr_exp);
            step(); smp();
            step(); smp();
            step(); r_rel = rr_exp; smp();
            step(); r_rel = 3'b000; smp();
            check_eq("rr_drain", r_grant, 3'b000);
            step(); smp();
        end
        step(); smp();
        check_eq("rr_after_wrap", r_grant, 3'b010);
        check_eq("rr_quiet", {r_mem_rd_en, r_mem_wr_en, |r_mem_addr_o, |r_mem_wd_o, r_bus_go, r_bus_rw,
                 |r_bus_addr_o, |r_bus_wr_o, |r_cl_mem_rd, |r_cl_mem_rv, |r_cl_bus_done, |r_cl_bus_rd,
                 r_sha_init, r_sha_next, r_sha_sel, |r_sha_blk_o}, 16'h0000);
        to_seen = 3'b000;
        for (int i = 0; i < 20; i++) begin
            step(); smp();
            to_seen = to_seen | r_to;
        end
        check_eq("rr_wd_disabled", to_seen, 3'b000);
        check_eq("rr_long_grant", r_grant, 3'b010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
